// File: rtl/ram_rsp.sv
// rtl/ram_rsp.sv - data-memory responder with fixed access latency and byte-masked writes
// One request in flight: IDLE accepts, WAIT counts down and performs the access, RESP holds the result.
module ram_rsp #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_data,
  input  logic [DATA_WIDTH/8-1:0] i_req_mask,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic                    o_rsp_err
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_W    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    lat_wr;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic [BYTES-1:0]        lat_mask;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req_fire, rsp_fire, access;
  logic [ADDR_WIDTH-1:0]   offset, word_idx;
  logic                    misaligned, out_of_range, acc_err;
  logic [IDX_W-1:0]        mem_idx;

  assign req_fire = i_req_valid & o_req_ready;
  assign rsp_fire = o_rsp_valid & i_rsp_ready;
  assign access   = (state == S_WAIT) && (cnt == 4'd0);

  // Offset subtraction wraps, so addresses below BASE_ADDR land far out of range.
  always_comb begin
    offset       = lat_addr - BASE_ADDR;
    word_idx     = offset >> OFF_BITS;
    misaligned   = (lat_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
    out_of_range = word_idx >= ADDR_WIDTH'(DEPTH);
    acc_err      = misaligned | out_of_range;
    mem_idx      = word_idx[IDX_W-1:0];
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_fire) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  if (rsp_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state == S_IDLE);
    o_rsp_valid = (state == S_RESP);
    o_rsp_data  = rsp_data_q;
    o_rsp_err   = rsp_err_q;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      cnt        <= '0;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_mask   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (req_fire) begin
        lat_wr   <= i_req_wr_en;
        lat_addr <= i_req_addr;
        lat_data <= i_req_data;
        lat_mask <= i_req_mask;
        cnt      <= 4'(LATENCY - 1);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_err_q  <= acc_err;
        rsp_data_q <= (acc_err || lat_wr) ? '0 : mem[mem_idx];
      end else if (rsp_fire) begin
        rsp_err_q  <= 1'b0;
        rsp_data_q <= '0;
      end
    end
  end

  // Array has no reset; a reset during WAIT forces IDLE so the pending write never commits.
  always_ff @(posedge i_sys_clk) begin
    if (access && lat_wr && !acc_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (lat_mask[b]) mem[mem_idx][8*b +: 8] <= lat_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_rsp.sv
// tb/tb_ram_rsp.sv - self-checking bench for ram_rsp at latencies 2, 1 and 15
// Instance 0 runs the directed table and corner sequences; all instances run random traffic.
module tb_ram_rsp;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr [3];
  logic [31:0] req_data [3];
  logic [3:0]  req_mask [3];
  logic [31:0] rsp_data [3];

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] mdl [3][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_rsp #(.LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .i_sys_clk  (clk),
      .i_sys_rst_n(rst_n),
      .i_req_valid(req_valid[g]),
      .o_req_ready(req_ready[g]),
      .i_req_wr_en(req_wr[g]),
      .i_req_addr (req_addr[g]),
      .i_req_data (req_data[g]),
      .i_req_mask (req_mask[g]),
      .o_rsp_valid(rsp_valid[g]),
      .i_rsp_ready(rsp_ready[g]),
      .o_rsp_data (rsp_data[g]),
      .o_rsp_err  (rsp_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: word memory indexed by byte offset / 4; anything misaligned or past 1023 is an error.
  task automatic model(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] ed, output logic ee);
    logic [31:0] off;
    off = a - BASE;
    ed = 32'h0;
    ee = (a % 4 != 0) || (off / 4 >= 1024);
    if (!ee) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) if (m[b]) mdl[k][off/4][8*b +: 8] = d[8*b +: 8];
      end else begin
        ed = mdl[k][off/4];
      end
    end
  endtask

  task automatic xact(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input bit bp, output logic [31:0] rd, output logic er);
    int  lat;
    bit  wait_ok, stable;
    @(negedge clk);
    req_valid[k] = 1'b1; req_wr[k] = wr; req_addr[k] = a; req_data[k] = d; req_mask[k] = m;
    rsp_ready[k] = 1'b0;
    chk("req_ready_idle", 32'(req_ready[k]), 32'h1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_wr[k] = $urandom; req_addr[k] = $urandom;
    req_data[k] = $urandom; req_mask[k] = 4'($urandom);
    lat = 0; wait_ok = 1'b1;
    do begin
      if (req_ready[k] !== 1'b0) wait_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end while (rsp_valid[k] !== 1'b1 && lat < 40);
    chk("latency", 32'(lat), 32'(lat_of(k)));
    chk("ready_low_in_wait", 32'(wait_ok), 32'h1);
    chk("ready_low_in_resp", 32'(req_ready[k]), 32'h0);
    rd = rsp_data[k]; er = rsp_err[k];
    if (bp) begin
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        req_valid[k] = 1'b1; req_wr[k] = $urandom; req_addr[k] = BASE;
        @(posedge clk); #1;
        if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== rd || rsp_err[k] !== er || req_ready[k] !== 1'b0)
          stable = 1'b0;
      end
      chk("backpressure_stable", 32'(stable), 32'h1);
    end
    @(negedge clk);
    req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    chk("rsp_valid_drop", 32'(rsp_valid[k]), 32'h0);
    chk("req_ready_back", 32'(req_ready[k]), 32'h1);
    chk("rsp_data_clear", rsp_data[k], 32'h0);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
  endtask

  task automatic run_and_check(input int k, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] m, input bit bp);
    logic [31:0] rd, ed;
    logic        er, ee;
    model(k, wr, a, d, m, ed, ee);
    xact(k, wr, a, d, m, bp, rd, er);
    chk("rand_data", rd, ed);
    chk("rand_err", 32'(er), 32'(ee));
  endtask

  task automatic random_phase(input int k, input int nops);
    logic [31:0] a;
    int          sel, w;
    for (int i = 0; i < 16; i++) run_and_check(k, 1'b1, BASE + 32'(4*i), $urandom, 4'hF, 1'b0);
    for (int i = 0; i < nops; i++) begin
      sel = $urandom_range(0, 9);
      w   = $urandom_range(0, 15);
      if (sel < 7)       a = BASE + 32'(4*w);
      else if (sel == 7) a = BASE + 32'(4*w) + 32'($urandom_range(1, 3));
      else if (sel == 8) a = BASE + 32'h1000 + 32'(4*$urandom_range(0, 255));
      else               a = BASE - 32'(4*$urandom_range(1, 64));
      run_and_check(k, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 7) == 0);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rd, ed;
    logic        er, ee;

    vecs[0]  = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0FFC, 32'h0BAD_CAFE, 4'hF, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0BAD_CAFE, 1'b0};
    vecs[6]  = '{1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0BAD_CAFE, 1'b0};
    vecs[12] = '{1'b1, 32'h8000_0004, 32'hAAAA_AAAA, 4'h0, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'h1234_5678, 1'b0};

    req_valid = '0; req_wr = '0; rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k] = '0; req_data[k] = '0; req_mask[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_req_ready", 32'(req_ready[k]), 32'h1);
      chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'h0);
      chk("reset_rsp_data", rsp_data[k], 32'h0);
      chk("reset_rsp_err", 32'(rsp_err[k]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      model(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, ed, ee);
      xact(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, 1'b0, rd, er);
      chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    xact(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b1, rd, er);
    chk("bp_read_data", rd, 32'hDE22_BE44);
    chk("bp_read_err", 32'(er), 32'h0);

    model(0, 1'b1, 32'h8000_0014, 32'h55AA_55AA, 4'hF, ed, ee);
    xact(0, 1'b1, 32'h8000_0014, 32'h55AA_55AA, 4'hF, 1'b0, rd, er);
    @(negedge clk);
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 32'h8000_0014;
    req_data[0] = 32'hCAFE_F00D; req_mask[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready[0]), 32'h1);
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("abort_rsp_data", rsp_data[0], 32'h0);
    chk("abort_rsp_err", 32'(rsp_err[0]), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_valid[0]), 32'h0);
    xact(0, 1'b0, 32'h8000_0014, 32'h0, 4'h0, 1'b0, rd, er);
    chk("abort_word5", rd, 32'h55AA_55AA);

    random_phase(0, 60);
    random_phase(1, 60);
    random_phase(2, 25);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
